instruction_fetch_arbiter: RTL and testbench
============================================

INSTRUCTION_FETCH_ARBITER -- requirements
Module: instruction_fetch_arbiter

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, byte address loaded into PC on reset.
REQ-002 SHALL have parameter DBG_STARVE_LIMIT, default 8, cycles a pending debug request waits before it is forced in.
REQ-003 Clk  in  1  sole clock, all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high.
REQ-005 Stall  in  1  downstream cannot accept a fetched instruction.
REQ-006 BranchValid  in  1  redirect request; BranchTarget  in  32  redirect byte address.
REQ-007 DbgReq  in  1  debug readback request; DbgAddr  in  32  byte address; both held until DbgGrant.
REQ-008 IMemAddr  out  32  byte address to the instruction memory; IMemData  in  32  its combinational read data.
REQ-009 PC  out  32  next fetch address; IFInstr  out  32  fetched word; IFPC  out  32  address of IFInstr; IFValid  out  1  IFInstr is valid.
REQ-010 DbgGrant  out  1  memory port owned by debug this cycle; DbgData  out  32  read word; DbgValid  out  1  one-cycle pulse, DbgData valid.

Function
REQ-011 States: BOOT, FETCH, DBG; BOOT lasts one cycle (IFValid=0) then FETCH.
REQ-012 IMemAddr SHALL be {PC[31:2],2'b00} in BOOT/FETCH and {DbgAddr[31:2],2'b00} in DBG; bits [1:0] always 0.
REQ-013 FETCH, Stall=0, BranchValid=0: IFInstr<=IMemData, IFPC<=PC, IFValid<=1, PC<=PC+4 (mod 2^32, 32'hFFFFFFFC wraps to 0).
REQ-014 FETCH, Stall=1, BranchValid=0: PC, IFInstr, IFPC, IFValid SHALL hold.
REQ-015 BranchValid=1 in any non-reset state SHALL set PC<=BranchTarget&~3, IFValid<=0, IFInstr<=0; overrides Stall.
REQ-016 Debug grant: in FETCH with DbgReq=1, next state DBG if Stall=1 or starve counter == DBG_STARVE_LIMIT.
REQ-017 Starve counter SHALL increment each cycle DbgReq=1 and DbgGrant=0, saturate at DBG_STARVE_LIMIT, clear on DbgGrant or DbgReq=0.
REQ-018 DbgGrant SHALL equal (state==DBG); DBG lasts exactly one cycle, then FETCH; DBG never in consecutive cycles.
REQ-019 In DBG: DbgData<=IMemData, DbgValid<=1 next cycle; PC holds (unless REQ-015); IF registers hold if Stall=1, else IFValid<=0, IFInstr<=0 (bubble).
REQ-020 DbgValid SHALL be 0 in every cycle not directly after a DBG cycle; DbgData holds between grants.
REQ-021 Latency: instruction at address A appears on IFInstr one cycle after PC==A in FETCH with Stall=0.

Reset
REQ-022 Reset=1 SHALL, at the next edge, set state=BOOT, PC=RESET_PC, IFInstr=0, IFPC=0, IFValid=0, DbgData=0, DbgValid=0, starve counter=0, overriding all other inputs including mid-DBG.
REQ-023 DbgGrant SHALL be 0 in the cycle following reset.

Configuration
REQ-024 Macro IFETCH_DBG_PORT_EN defined: debug arbitration per REQ-016..REQ-020.
REQ-025 Macro IFETCH_DBG_PORT_EN undefined: no DBG state or starve counter; DbgReq/DbgAddr ignored; DbgGrant, DbgValid, DbgData tied 0; IMemAddr always from PC.

Verification
REQ-026 Reset with RESET_PC=0, memory[i]=i*4, Stall=0 -> BOOT bubble, then IFInstr 0,4,8,... with IFPC equal, IFValid=1.
REQ-027 Stall=1 for 3 cycles at PC=0x10 -> IFInstr/IFPC/PC frozen, resume at 0x10 with no skip or duplicate.
REQ-028 BranchValid=1, BranchTarget=0x43, Stall=1 -> next cycle IFValid=0, PC=0x40; following cycle IFInstr=memory[16].
REQ-029 DbgReq=1, DbgAddr=0x20, Stall=1 -> DbgGrant next cycle, DbgValid pulse with DbgData=0x20, fetch unchanged.
REQ-030 DbgReq=1, Stall=0 continuously, DBG_STARVE_LIMIT=8 -> grant after 8 waiting cycles, one IF bubble, PC not advanced that cycle.
REQ-031 Reset asserted in DBG cycle, PC=0xFFFFFFFC wrap case -> all outputs at reset values; wrap to 0x00000000 without reset.

Source files
------------

// File: rtl/instruction_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// instruction_fetch_arbiter
//
// Purpose:
//   Sequential instruction fetch front end that shares one combinational
//   instruction-memory read port between the fetch path and an optional
//   debug readback port. After reset there is a single BOOT bubble, then the
//   block fetches one word per cycle from PC, holding on Stall and
//   redirecting on BranchValid. Debug reads steal the port for exactly one
//   cycle (DBG), either opportunistically while the pipe is stalled or
//   forcibly once a request has waited DBG_STARVE_LIMIT cycles.
//
// Configuration macro:
//   IFETCH_DBG_PORT_EN  defined   -> debug arbitration present (DBG state,
//                                    starve counter, readback registers).
//                       undefined -> debug inputs ignored, debug outputs 0,
//                                    memory address always comes from PC.
//
// Parameters:
//   RESET_PC          byte address loaded into PC on reset
//   DBG_STARVE_LIMIT  waiting cycles before a debug request is forced in
//
// Ports:
//   i_clk            sole clock, rising edge
//   i_reset          synchronous, active-high reset
//   i_stall          downstream cannot accept a fetched instruction
//   i_branch_valid   redirect request (overrides stall)
//   i_branch_target  redirect byte address (low two bits ignored)
//   i_dbg_req        debug readback request, held until o_dbg_grant
//   i_dbg_addr       debug readback byte address
//   o_imem_addr      word-aligned byte address to instruction memory
//   i_imem_data      combinational read data for o_imem_addr
//   o_pc             next fetch address
//   o_if_instr       fetched instruction word
//   o_if_pc          address of o_if_instr
//   o_if_valid       o_if_instr is valid
//   o_dbg_grant      memory port owned by debug this cycle
//   o_dbg_data       debug readback word (held between grants)
//   o_dbg_valid      one-cycle pulse, o_dbg_data freshly updated
// -----------------------------------------------------------------------------
module instruction_fetch_arbiter #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int unsigned DBG_STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_valid,
  input  logic [31:0] i_branch_target,
  input  logic        i_dbg_req,
  input  logic [31:0] i_dbg_addr,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_if_valid,
  output logic        o_dbg_grant,
  output logic [31:0] o_dbg_data,
  output logic        o_dbg_valid
);

  // Clears the byte offset so the memory always sees a word address.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

`ifdef IFETCH_DBG_PORT_EN
  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_DBG} state_t;
`else
  typedef enum logic [1:0] {ST_BOOT, ST_FETCH} state_t;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_if_instr;
  logic [31:0] w_if_instr_next;
  logic [31:0] r_if_pc;
  logic [31:0] w_if_pc_next;
  logic        r_if_valid;
  logic        w_if_valid_next;

`ifdef IFETCH_DBG_PORT_EN
  localparam int unsigned SC_W = (DBG_STARVE_LIMIT < 1) ? 1 : $clog2(DBG_STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(DBG_STARVE_LIMIT);

  logic [SC_W-1:0] r_starve;
  logic [31:0]     r_dbg_data;
  logic            r_dbg_valid;
  logic            w_dbg_grant;
  logic            w_dbg_win;

  assign w_dbg_grant = (r_state == ST_DBG);
  // A pending request wins the port when fetch has nothing to do anyway
  // (stall), or once it has waited long enough that it must be forced in.
  assign w_dbg_win   = i_dbg_req && (i_stall || (r_starve == STARVE_MAX));
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_if_instr_next = r_if_instr;
    w_if_pc_next    = r_if_pc;
    w_if_valid_next = r_if_valid;

    case (r_state)
      ST_BOOT: begin
        // Single bubble cycle; IF registers keep their reset values.
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (!i_stall) begin
          w_if_instr_next = i_imem_data;
          w_if_pc_next    = r_pc;
          w_if_valid_next = 1'b1;
          w_pc_next       = r_pc + 32'd4;
        end
`ifdef IFETCH_DBG_PORT_EN
        if (w_dbg_win) begin
          w_state_next = ST_DBG;
        end
`endif
      end
`ifdef IFETCH_DBG_PORT_EN
      ST_DBG: begin
        // Port was lent to debug: no instruction was read for the pipe, so
        // insert a bubble unless downstream is still holding the old one.
        w_state_next = ST_FETCH;
        if (!i_stall) begin
          w_if_valid_next = 1'b0;
          w_if_instr_next = 32'd0;
        end
      end
`endif
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase

    // Redirect wins over stall and over whatever the state produced.
    if (i_branch_valid) begin
      w_pc_next       = i_branch_target & WORD_MASK;
      w_if_valid_next = 1'b0;
      w_if_instr_next = 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_if_instr <= w_if_instr_next;
      r_if_pc    <= w_if_pc_next;
      r_if_valid <= w_if_valid_next;
    end
  end

`ifdef IFETCH_DBG_PORT_EN
  // Starve counter counts cycles a request sits ungranted and saturates so
  // the forced-grant compare stays true until the grant actually happens.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve    <= '0;
      r_dbg_data  <= 32'd0;
      r_dbg_valid <= 1'b0;
    end else begin
      if (i_dbg_req && !w_dbg_grant) begin
        if (r_starve != STARVE_MAX) begin
          r_starve <= r_starve + SC_W'(1);
        end
      end else begin
        r_starve <= '0;
      end
      r_dbg_valid <= w_dbg_grant;
      if (w_dbg_grant) begin
        r_dbg_data <= i_imem_data;
      end
    end
  end

  assign o_imem_addr = w_dbg_grant ? (i_dbg_addr & WORD_MASK) : (r_pc & WORD_MASK);
  assign o_dbg_grant = w_dbg_grant;
  assign o_dbg_data  = r_dbg_data;
  assign o_dbg_valid = r_dbg_valid;
`else
  // Debug port absent: inputs are deliberately left without effect.
  logic w_unused_dbg;
  assign w_unused_dbg = &{1'b0, i_dbg_req, i_dbg_addr, (DBG_STARVE_LIMIT != 0)};

  assign o_imem_addr = r_pc & WORD_MASK;
  assign o_dbg_grant = 1'b0;
  assign o_dbg_data  = 32'd0;
  assign o_dbg_valid = 1'b0;
`endif

  assign o_pc       = r_pc;
  assign o_if_instr = r_if_instr;
  assign o_if_pc    = r_if_pc;
  assign o_if_valid = r_if_valid;

endmodule

// File: tb/tb_instruction_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_arbiter
//
// Self-checking bench for instruction_fetch_arbiter: reset checks, a table of
// directed fetch/stall/branch/wrap vectors with hand-derived expectations,
// directed debug sequences, then randomized traffic compared every cycle
// against a cycle-level behavioural model. Inputs are driven on the falling
// edge and outputs sampled on the falling edge after each rising edge.
// Follows the IFETCH_DBG_PORT_EN macro in the same way as the design.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_arbiter;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          LIMIT    = 8;
`ifdef IFETCH_DBG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, br_valid, dbg_req;
  logic [31:0] br_target, dbg_addr;
  logic [31:0] imem_addr, imem_data, pc, if_instr, if_pc, dbg_data;
  logic        if_valid, dbg_grant, dbg_valid;
  bit          scramble;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory: word i holds i*4 (data equals its own address) unless scrambled.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return scramble ? ((a * 32'h9E37_79B1) ^ 32'hA5A5_0000) : a;
  endfunction

  assign imem_data = mem_rd(imem_addr);

  instruction_fetch_arbiter #(
    .RESET_PC        (RESET_PC),
    .DBG_STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_stall        (stall),
    .i_branch_valid (br_valid),
    .i_branch_target(br_target),
    .i_dbg_req      (dbg_req),
    .i_dbg_addr     (dbg_addr),
    .o_imem_addr    (imem_addr),
    .i_imem_data    (imem_data),
    .o_pc           (pc),
    .o_if_instr     (if_instr),
    .o_if_pc        (if_pc),
    .o_if_valid     (if_valid),
    .o_dbg_grant    (dbg_grant),
    .o_dbg_data     (dbg_data),
    .o_dbg_valid    (dbg_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: what the outputs must be, expressed from the rules.
  // m_boot    : this cycle is the post-reset bubble
  // m_granted : this cycle the memory port belongs to debug
  // m_wait    : cycles the current debug request has waited (saturating)
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_instr, m_ifpc, m_ddata;
  logic        m_valid, m_dvalid, m_boot, m_granted;
  int          m_wait;

  task automatic model_step();
    logic [31:0] rd;
    logic        was_granted;
    if (reset) begin
      m_pc = RESET_PC; m_instr = 0; m_ifpc = 0; m_valid = 0;
      m_ddata = 0; m_dvalid = 0; m_boot = 1; m_granted = 0; m_wait = 0;
      return;
    end
    was_granted = m_granted;
    rd = mem_rd(was_granted ? (dbg_addr & ~32'h3) : (m_pc & ~32'h3));
    m_dvalid = was_granted;
    if (was_granted) m_ddata = rd;
    m_granted = DBG_EN && !m_boot && !was_granted && dbg_req && (stall || m_wait == LIMIT);
    m_wait = (DBG_EN && dbg_req && !was_granted) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
    if (br_valid) begin
      m_pc = br_target & ~32'h3; m_valid = 0; m_instr = 0;
    end else if (!m_boot && !was_granted && !stall) begin
      m_instr = rd; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
    end else if (was_granted && !stall) begin
      m_valid = 0; m_instr = 0;
    end
    m_boot = 0;
  endtask

  // One clock: check combinational outputs for the current inputs, advance
  // the model, clock the DUT, then check registered outputs.
  task automatic tick();
    if (!reset) begin
      chk("imem_addr", imem_addr, m_granted ? (dbg_addr & ~32'h3) : (m_pc & ~32'h3));
      chk("dbg_grant", dbg_grant, m_granted);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("if_valid", if_valid, m_valid);
    chk("if_instr", if_instr, m_instr);
    if (m_valid) chk("if_pc", if_pc, m_ifpc);
    chk("dbg_valid", dbg_valid, m_dvalid);
    chk("dbg_data", dbg_data, m_ddata);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_ifpc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic [31:0] p, input logic v,
                              input logic [31:0] ins, input logic [31:0] ipc);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.e_pc = p; r.e_v = v; r.e_instr = ins; r.e_ifpc = ipc;
    return r;
  endfunction

  vec_t vt [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int grants;
    logic [31:0] pc_g;

    // Expected outputs after each vector's clock edge (memory word = address).
    vt[0]  = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0);  // BOOT bubble
    vt[1]  = mk(0, 0, 32'h0,        32'h4,        1, 32'h0,        32'h0);
    vt[2]  = mk(0, 0, 32'h0,        32'h8,        1, 32'h4,        32'h4);
    vt[3]  = mk(0, 0, 32'h0,        32'hC,        1, 32'h8,        32'h8);
    vt[4]  = mk(0, 0, 32'h0,        32'h10,       1, 32'hC,        32'hC);
    vt[5]  = mk(1, 0, 32'h0,        32'h10,       1, 32'hC,        32'hC);  // stall x3
    vt[6]  = mk(1, 0, 32'h0,        32'h10,       1, 32'hC,        32'hC);
    vt[7]  = mk(1, 0, 32'h0,        32'h10,       1, 32'hC,        32'hC);
    vt[8]  = mk(0, 0, 32'h0,        32'h14,       1, 32'h10,       32'h10); // resume at 0x10
    vt[9]  = mk(1, 1, 32'h43,       32'h40,       0, 32'h0,        32'h0);  // branch beats stall
    vt[10] = mk(0, 0, 32'h0,        32'h44,       1, 32'h40,       32'h40); // memory[16]
    vt[11] = mk(0, 1, 32'hFFFFFFFE, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
    vt[12] = mk(0, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC); // wrap
    vt[13] = mk(0, 1, 32'h8,        32'h8,        0, 32'h0,        32'h0);
    vt[14] = mk(0, 0, 32'h0,        32'hC,        1, 32'h8,        32'h8);

    scramble = 0;
    reset = 1; stall = 0; br_valid = 0; br_target = 0; dbg_req = 0; dbg_addr = 0;
    @(negedge clk);
    tick();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_dbg_valid", dbg_valid, 0);
    chk("rst_dbg_data", dbg_data, 0);
    chk("rst_dbg_grant", dbg_grant, 0);
    reset = 0;

    for (int i = 0; i < 15; i++) begin
      stall = vt[i].stall; br_valid = vt[i].br; br_target = vt[i].tgt;
      tick();
      chk("tbl_pc", pc, vt[i].e_pc);
      chk("tbl_if_valid", if_valid, vt[i].e_v);
      chk("tbl_if_instr", if_instr, vt[i].e_instr);
      if (vt[i].e_v) chk("tbl_if_pc", if_pc, vt[i].e_ifpc);
      $display("vec %0d stall=%0b br=%0b tgt=%h -> pc=%h v=%0b instr=%h ifpc=%h",
               i, vt[i].stall, vt[i].br, vt[i].tgt, pc, if_valid, if_instr, if_pc);
    end
    br_valid = 0; br_target = 0;

`ifdef IFETCH_DBG_PORT_EN
    // Opportunistic grant while stalled; fetch state untouched.
    stall = 1; dbg_req = 1; dbg_addr = 32'h20;
    tick();
    chk("d_stall_grant", dbg_grant, 1);
    chk("d_stall_addr", imem_addr, 32'h20);
    dbg_req = 0;
    tick();
    chk("d_stall_dvalid", dbg_valid, 1);
    chk("d_stall_ddata", dbg_data, 32'h20);
    chk("d_stall_pc", pc, 32'hC);
    chk("d_stall_instr", if_instr, 32'h8);
    $display("dbg read addr=%h data=%h (stalled)", 32'h20, dbg_data);
    stall = 0;
    tick();
    chk("d_pulse_end", dbg_valid, 0);

    // Forced grant after starvation with fetch running.
    dbg_req = 1; dbg_addr = 32'h24; waited = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (dbg_grant) begin waited = n; break; end
    end
    chk("d_starve_cycles", waited, LIMIT + 1);
    pc_g = pc;
    dbg_req = 0;
    tick();
    chk("d_starve_pc_hold", pc, pc_g);
    chk("d_starve_bubble", if_valid, 0);
    chk("d_starve_dvalid", dbg_valid, 1);
    chk("d_starve_ddata", dbg_data, 32'h24);
    $display("dbg read addr=%h data=%h after %0d cycles", 32'h24, dbg_data, waited);

    // Reset landing on a DBG cycle.
    stall = 1; dbg_req = 1; dbg_addr = 32'h28;
    tick();
    chk("d_rst_grant", dbg_grant, 1);
    reset = 1; dbg_req = 0;
    tick();
    chk("d_rst_dvalid", dbg_valid, 0);
    chk("d_rst_ddata", dbg_data, 0);
    chk("d_rst_pc", pc, RESET_PC);
    chk("d_rst_grant_after", dbg_grant, 0);
    reset = 0; stall = 0;
    $display("reset during debug grant");
`else
    // Debug port absent: requests never granted, fetch keeps advancing.
    dbg_req = 1; dbg_addr = 32'h20; grants = 0;
    pc_g = pc;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (dbg_grant || dbg_valid) grants++;
    end
    chk("nodbg_grants", grants, 0);
    chk("nodbg_pc", pc, pc_g + 32'd48);
    chk("nodbg_data", dbg_data, 0);
    dbg_req = 0;
    $display("debug requests ignored for 12 cycles, pc=%h", pc);
`endif

    // Randomized traffic against the model.
    scramble = 1;
    for (int c = 0; c < 800; c++) begin
      reset    = ($urandom_range(0, 99) < 2);
      stall    = ($urandom_range(0, 99) < 30);
      br_valid = ($urandom_range(0, 99) < 8);
      br_target = $urandom;
      if (m_granted) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 99) < 10) begin
        dbg_req = 1; dbg_addr = $urandom;
      end
      tick();
      if (dbg_valid) $display("rand dbg read data=%h", dbg_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
